// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with TX/RX FIFOs (valid/ready) and
// sticky RX error flags. uart_fifo is the shared first-word-fall-through buffer.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

module uart_core #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        rx_i,
    output logic                        tx_o,
    input  logic [DATA_BITS-1:0]        tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic [DATA_BITS-1:0]        rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic                        rx_frame_err_o,
    output logic                        rx_parity_err_o,
    output logic                        rx_overrun_o,
    input  logic                        err_clear_i,
    output logic                        tx_busy_o,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o
);
    localparam int             CW       = $clog2(CLK_DIV);
    localparam int             BW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic           ODD      = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // ---------------- transmitter ----------------
    logic                 tx_full, tx_empty, tx_pop, tx_bit_end, tx_last_stop;
    logic [DATA_BITS-1:0] tx_head;
    state_e               tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q, tx_q;

    assign tx_ready_o   = !tx_full;
    assign tx_o         = tx_q;
    assign tx_busy_o    = (tx_state_q != S_IDLE) || !tx_empty;
    assign tx_bit_end   = (tx_cnt_q == BIT_END);
    assign tx_last_stop = (tx_state_q == S_STOP) && tx_bit_end && (tx_bit_q == BW'(STOP_BITS - 1));
    // Popping at the end of the last stop bit gives back-to-back frames with no idle gap.
    assign tx_pop       = !tx_empty && ((tx_state_q == S_IDLE) || tx_last_stop);

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .nreset(nreset), .push_i(tx_valid_i && tx_ready_o), .data_i(tx_data_i),
        .pop_i(tx_pop), .data_o(tx_head), .level_o(tx_level_o), .full_o(tx_full), .empty_o(tx_empty)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
            case (tx_state_q)
                S_IDLE: begin
                    tx_cnt_q <= '0;
                    if (tx_pop) begin
                        tx_shift_q <= tx_head;
                        tx_par_q   <= (^tx_head) ^ ODD;
                        tx_q       <= 1'b0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: if (tx_bit_end) begin
                    tx_q       <= tx_shift_q[0];
                    tx_bit_q   <= '0;
                    tx_state_q <= S_DATA;
                end
                S_DATA: if (tx_bit_end) begin
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        tx_bit_q   <= '0;
                        tx_q       <= (PARITY != 0) ? tx_par_q : 1'b1;
                        tx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_q       <= tx_shift_q[1];
                        tx_bit_q   <= tx_bit_q + 1'b1;
                    end
                end
                S_PARITY: if (tx_bit_end) begin
                    tx_q       <= 1'b1;
                    tx_state_q <= S_STOP;
                end
                S_STOP: if (tx_bit_end) begin
                    if (!tx_last_stop) begin
                        tx_bit_q <= tx_bit_q + 1'b1;
                    end else if (tx_pop) begin
                        tx_shift_q <= tx_head;
                        tx_par_q   <= (^tx_head) ^ ODD;
                        tx_q       <= 1'b0;
                        tx_state_q <= S_START;
                    end else begin
                        tx_state_q <= S_IDLE;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    logic                 rx_full, rx_empty, rx_pop, rx_push, rx_sample, rx_par_ok;
    state_e               rx_state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_bit_q;

    assign rx_fall    = rx_s3_q && !rx_s2_q;
    assign rx_sample  = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END);
    assign rx_par_ok  = (PARITY == 0) || (rx_par_bit_q == ((^rx_shift_q) ^ ODD));
    assign rx_push    = rx_sample && rx_s2_q && rx_par_ok;
    assign rx_valid_o = !rx_empty;
    assign rx_pop     = rx_valid_o && rx_ready_i;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .nreset(nreset), .push_i(rx_push), .data_i(rx_shift_q),
        .pop_i(rx_pop), .data_o(rx_data_o), .level_o(rx_level_o), .full_o(rx_full), .empty_o(rx_empty)
    );

    // Synchroniser resets to the idle level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bit_q <= 1'b0;
        end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_fall) rx_state_q <= S_START;
                end
                S_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1))
                        rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        rx_bit_q <= rx_bit_q + 1'b1;
                end
                S_PARITY: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q     <= '0;
                    rx_par_bit_q <= rx_s2_q;
                    rx_state_q   <= S_STOP;
                end
                S_STOP: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= S_IDLE;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // Set wins over err_clear_i when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rx_frame_err_o  <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            rx_frame_err_o  <= (rx_sample && !rx_s2_q) || (rx_frame_err_o && !err_clear_i);
            rx_parity_err_o <= (rx_sample && rx_s2_q && !rx_par_ok) || (rx_parity_err_o && !err_clear_i);
            rx_overrun_o    <= (rx_push && rx_full && !rx_pop) || (rx_overrun_o && !err_clear_i);
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (8N1, 8E2 loopback, 8O1) with
// scoreboard queues for wire bits and received bytes.
module tb_uart_core;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic rx_drv = 1'b1;
    int   rx_sel = 0;

    logic       rx_a, tx_a, tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, rx_ready_a = 1'b0;
    logic       fe_a, pe_a, ov_a, clr_a = 1'b0, busy_a;
    logic [7:0] tx_data_a = '0, rx_data_a;
    logic [2:0] tx_level_a, rx_level_a;

    logic       tx_b, tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, rx_ready_b = 1'b0;
    logic       fe_b, pe_b, ov_b, busy_b;
    logic [7:0] tx_data_b = '0, rx_data_b;
    logic [2:0] tx_level_b, rx_level_b;

    logic       rx_c, tx_c, tx_ready_c, rx_valid_c, rx_ready_c = 1'b0;
    logic       fe_c, pe_c, ov_c, clr_c = 1'b0, busy_c;
    logic [7:0] rx_data_c;
    logic [2:0] tx_level_c, rx_level_c;

    assign rx_a = (rx_sel == 0) ? rx_drv : 1'b1;
    assign rx_c = (rx_sel == 1) ? rx_drv : 1'b1;

    uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)) u_a (
        .clk(clk), .nreset(nreset), .rx_i(rx_a), .tx_o(tx_a), .tx_data_i(tx_data_a), .tx_valid_i(tx_valid_a),
        .tx_ready_o(tx_ready_a), .rx_data_o(rx_data_a), .rx_valid_o(rx_valid_a), .rx_ready_i(rx_ready_a),
        .rx_frame_err_o(fe_a), .rx_parity_err_o(pe_a), .rx_overrun_o(ov_a), .err_clear_i(clr_a),
        .tx_busy_o(busy_a), .tx_level_o(tx_level_a), .rx_level_o(rx_level_a));

    uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .TX_DEPTH(4), .RX_DEPTH(4)) u_b (
        .clk(clk), .nreset(nreset), .rx_i(tx_b), .tx_o(tx_b), .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b),
        .tx_ready_o(tx_ready_b), .rx_data_o(rx_data_b), .rx_valid_o(rx_valid_b), .rx_ready_i(rx_ready_b),
        .rx_frame_err_o(fe_b), .rx_parity_err_o(pe_b), .rx_overrun_o(ov_b), .err_clear_i(1'b0),
        .tx_busy_o(busy_b), .tx_level_o(tx_level_b), .rx_level_o(rx_level_b));

    uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)) u_c (
        .clk(clk), .nreset(nreset), .rx_i(rx_c), .tx_o(tx_c), .tx_data_i(8'h00), .tx_valid_i(1'b0),
        .tx_ready_o(tx_ready_c), .rx_data_o(rx_data_c), .rx_valid_o(rx_valid_c), .rx_ready_i(rx_ready_c),
        .rx_frame_err_o(fe_c), .rx_parity_err_o(pe_c), .rx_overrun_o(ov_c), .err_clear_i(clr_c),
        .tx_busy_o(busy_c), .tx_level_o(tx_level_c), .rx_level_o(rx_level_c));

    logic       wire_q[$];
    logic [7:0] exp_a[$], exp_b[$], exp_c[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wire(input logic b, input int n);
        for (int i = 0; i < n; i++) wire_q.push_back(b);
    endtask

    // Expected per-cycle TX waveform of one frame.
    task automatic enc_wire(input logic [7:0] d, input int par_mode, input int stops);
        push_wire(1'b0, DIV);
        for (int i = 0; i < 8; i++) push_wire(d[i], DIV);
        if (par_mode != 0) push_wire((^d) ^ (par_mode == 1), DIV);
        push_wire(1'b1, stops * DIV);
    endtask

    task automatic drive_frame(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (DIV) tick();
        end
        rx_drv = 1'b1;
    endtask

    task automatic drain_a(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_valid_a && rx_ready_a) begin
                check("a_pop_expected", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) check("a_pop_data", rx_data_a, exp_a.pop_front());
            end
            tick();
        end
    endtask

    task automatic drain_c(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_valid_c && rx_ready_c) begin
                check("c_pop_expected", exp_c.size() > 0, 1);
                if (exp_c.size() > 0) check("c_pop_data", rx_data_c, exp_c.pop_front());
            end
            tick();
        end
    endtask

    initial begin
        int accepted;
        logic [7:0] d;

        repeat (3) tick();
        check("rst_tx_o", tx_a, 1);
        check("rst_tx_ready", tx_ready_a, 1);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_flags", {fe_a, pe_a, ov_a}, 0);
        check("rst_levels", {tx_level_a, rx_level_a}, 0);
        check("rst_busy", busy_a, 0);
        nreset = 1'b1;
        tick();

        // 8N1 encode of 0x55: low two cycles after the write, 40-cycle frame.
        tx_data_a = 8'h55; tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        check("t1_busy_rise", busy_a, 1);
        check("t1_tx_still_idle", tx_a, 1);
        tick();
        enc_wire(8'h55, 0, 1);
        for (int i = 0; i < 40; i++) begin
            check("t1_wire", tx_a, wire_q.pop_front());
            if (i == 39) check("t1_busy_last", busy_a, 1);
            tick();
        end
        check("t1_busy_fall", busy_a, 0);
        check("t1_tx_idle_after", tx_a, 1);

        // 8E2 loopback burst: back-to-back frames and three clean receptions.
        rx_ready_b = 1'b1;
        wire_q.delete();
        exp_b.push_back(8'hA5); exp_b.push_back(8'h00); exp_b.push_back(8'hFF);
        enc_wire(8'hA5, 2, 2); enc_wire(8'h00, 2, 2); enc_wire(8'hFF, 2, 2);
        tx_data_b = 8'hA5; tx_valid_b = 1'b1;
        tick();
        check("t2_tx_still_idle", tx_b, 1);
        tx_data_b = 8'h00;
        tick();
        tx_data_b = 8'hFF;
        for (int i = 0; i < 144 + 40; i++) begin
            if (i < 144) check("t2_wire", tx_b, wire_q.pop_front());
            if (rx_valid_b) begin
                check("t2_pop_expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) check("t2_rx_data", rx_data_b, exp_b.pop_front());
            end
            tick();
            if (i == 0) tx_valid_b = 1'b0;
        end
        check("t2_all_received", exp_b.size(), 0);
        check("t2_flags", {fe_b, pe_b, ov_b}, 0);
        check("t2_tx_idle", busy_b, 0);

        // Glitch, then a frame with its stop bit held low.
        rx_sel = 0; rx_ready_a = 1'b1;
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        check("t3_glitch_valid", rx_valid_a, 0);
        check("t3_glitch_flags", {fe_a, pe_a, ov_a}, 0);
        drive_frame({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        repeat (4) tick();
        check("t3_frame_err", fe_a, 1);
        check("t3_no_push", rx_valid_a, 0);
        check("t3_rx_level", rx_level_a, 0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t3_cleared", fe_a, 0);

        // Odd parity: wrong parity bit drops the byte, correct one is pushed.
        rx_sel = 1; rx_ready_c = 1'b1;
        drive_frame({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        repeat (4) tick();
        check("t4_parity_err", pe_c, 1);
        check("t4_no_push", rx_valid_c, 0);
        check("t4_other_flags", {fe_c, ov_c}, 0);
        d = 8'h01;
        exp_c.push_back(d);
        drive_frame({5'b0, 1'b1, (^d) ^ 1'b1, d, 1'b0}, 11);
        drain_c(10);
        check("t4_good_received", exp_c.size(), 0);
        check("t4_parity_sticky", pe_c, 1);
        clr_c = 1'b1;
        tick();
        clr_c = 1'b0;
        check("t4_cleared", pe_c, 0);

        // Overrun: five frames into a 4-deep FIFO nobody drains.
        rx_sel = 0; rx_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h10 + 8'(i);
            if (i < 4) exp_a.push_back(d);
            drive_frame({6'b0, 1'b1, d, 1'b0}, 10);
        end
        repeat (4) tick();
        check("t5_rx_level", rx_level_a, 4);
        check("t5_overrun", ov_a, 1);
        check("t5_frame_err", fe_a, 0);
        rx_ready_a = 1'b1;
        drain_a(8);
        check("t5_all_popped", exp_a.size(), 0);
        check("t5_empty", rx_valid_a, 0);

        // Reset in the middle of a TX frame and an RX frame.
        tx_data_a = 8'h81; tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        rx_drv = 1'b0;
        repeat (10) tick();
        check("t6_mid_frame_tx_low", tx_a, 0);
        nreset = 1'b0;
        tick();
        check("t6_rst_tx_o", tx_a, 1);
        check("t6_rst_levels", {tx_level_a, rx_level_a}, 0);
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_flags", {fe_a, pe_a, ov_a}, 0);
        rx_drv = 1'b1;
        tick();
        nreset = 1'b1;
        repeat (10) tick();
        check("t6_tx_stays_idle", tx_a, 1);
        check("t6_rx_no_push", rx_valid_a, 0);
        exp_a.push_back(8'h5A);
        drive_frame({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        drain_a(10);
        check("t6_frame_after_reset", exp_a.size(), 0);
        check("t6_flags_after", {fe_a, pe_a, ov_a}, 0);

        // Fill the 4-deep TX FIFO while the transmitter pops the first entry.
        accepted = 0;
        tx_valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_data_a = 8'(i);
            if (tx_ready_a) accepted++;
            tick();
        end
        tx_valid_a = 1'b0;
        check("t6_accepted", accepted, 5);
        check("t6_tx_ready_low", tx_ready_a, 0);
        check("t6_tx_level_full", tx_level_a, 4);
        check("t6_tx_busy", busy_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
